// File: rtl/snake_pkg.sv
// Shared defaults, drive polarities and width helper for the snake matrix scan.
package snake_pkg;

    localparam int DEF_ROWS         = 8;
    localparam int DEF_COLS         = 8;
    localparam int DEF_DWELL        = 4;
    localparam int DEF_BLINK_FRAMES = 2;

    // Row cathodes sink current (active low), column anodes source it (active high).
    localparam logic ROW_ON = 1'b0;
    localparam logic COL_ON = 1'b1;

    // Index width for a count of n items, never narrower than one bit.
    function automatic int clog2w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/snake_matrix_scan_if.sv
// Load port and pin-side outputs of the snake matrix scan; master = game logic, slave = driver.
interface snake_matrix_scan_if
    import snake_pkg::*;
#(
    parameter int ROWS = DEF_ROWS,
    parameter int COLS = DEF_COLS
);
    localparam int IW = clog2w(ROWS * COLS);
    localparam int RW = clog2w(ROWS);

    logic                   in_load;
    logic [ROWS*COLS-1:0]   in_led_array_flat;
    logic                   in_blink_en;
    logic [IW-1:0]          in_blink_index;
    logic [ROWS-1:0]        out_row_cathode;
    logic [COLS-1:0]        out_column_anode;
    logic [RW-1:0]          out_row_index;
    logic                   out_frame_done;
    logic                   out_load_pending;

    modport master (
        output in_load, in_led_array_flat, in_blink_en, in_blink_index,
        input  out_row_cathode, out_column_anode, out_row_index, out_frame_done, out_load_pending
    );

    modport slave (
        input  in_load, in_led_array_flat, in_blink_en, in_blink_index,
        output out_row_cathode, out_column_anode, out_row_index, out_frame_done, out_load_pending
    );

endinterface

// File: rtl/snake_scan_counter.sv
// Dwell and row counters for the matrix scan; flags the blanking slot and the frame-end cycle.
module snake_scan_counter
    import snake_pkg::*;
#(
    parameter int ROWS  = DEF_ROWS,
    parameter int DWELL = DEF_DWELL
) (
    input  logic                      clk,
    input  logic                      srst,
    output logic [clog2w(ROWS)-1:0]   row_idx,
    output logic                      slot_blank,
    output logic                      frame_end
);
    localparam int RW = clog2w(ROWS);
    localparam int DW = clog2w(DWELL);
    localparam logic [RW-1:0] ROW_LAST   = RW'(ROWS - 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);

    logic [DW-1:0] dwell_reg;
    logic [RW-1:0] row_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            dwell_reg <= '0;
            row_reg   <= '0;
        end else if (dwell_reg == DWELL_LAST) begin
            dwell_reg <= '0;
            row_reg   <= (row_reg == ROW_LAST) ? '0 : row_reg + 1'b1;
        end else begin
            dwell_reg <= dwell_reg + 1'b1;
        end
    end

    assign row_idx    = row_reg;
    assign slot_blank = (dwell_reg == '0);
    assign frame_end  = (row_reg == ROW_LAST) && (dwell_reg == DWELL_LAST);

endmodule

// File: rtl/snake_matrix_scan.sv
// Row-multiplexed LED matrix driver with double-buffered frame load and frame-aligned swap.
// Optional cell blinking is built when SNAKE_BLINK_EN is defined.
module snake_matrix_scan
    import snake_pkg::*;
#(
    parameter int ROWS         = DEF_ROWS,
    parameter int COLS         = DEF_COLS,
    parameter int DWELL        = DEF_DWELL,
    parameter int BLINK_FRAMES = DEF_BLINK_FRAMES
) (
    input  logic                  in_clka,
    input  logic                  in_restart,
    snake_matrix_scan_if.slave    bus
);
    localparam int N  = ROWS * COLS;
    localparam int RW = clog2w(ROWS);

    logic [RW-1:0]   row_idx;
    logic            slot_blank;
    logic            frame_end;

    logic [N-1:0]    active_reg;
    logic [N-1:0]    shadow_reg;
    logic            pending_reg;
    logic [N-1:0]    blink_mask;
    logic [N-1:0]    display;
    logic [COLS-1:0] row_data [ROWS];

    logic [ROWS-1:0] cathode_reg, cathode_next;
    logic [COLS-1:0] anode_reg, anode_next;
    logic [RW-1:0]   row_index_reg;
    logic            frame_done_reg;

    snake_scan_counter #(
        .ROWS  (ROWS),
        .DWELL (DWELL)
    ) u_counter (
        .clk        (in_clka),
        .srst       (in_restart),
        .row_idx    (row_idx),
        .slot_blank (slot_blank),
        .frame_end  (frame_end)
    );

`ifdef SNAKE_BLINK_EN
    localparam int BW = clog2w(BLINK_FRAMES);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

    logic [BW-1:0] blink_cnt_reg;
    logic          phase_reg;

    // Phase flips after every BLINK_FRAMES completed frames while blinking is enabled.
    always_ff @(posedge in_clka) begin
        if (in_restart || !bus.in_blink_en) begin
            blink_cnt_reg <= '0;
            phase_reg     <= 1'b0;
        end else if (frame_end) begin
            if (blink_cnt_reg == BLINK_LAST) begin
                blink_cnt_reg <= '0;
                phase_reg     <= ~phase_reg;
            end else begin
                blink_cnt_reg <= blink_cnt_reg + 1'b1;
            end
        end
    end

    always_comb begin
        blink_mask = '0;
        if (phase_reg && bus.in_blink_en && (int'(bus.in_blink_index) < N))
            blink_mask[bus.in_blink_index] = 1'b1;
    end
`else
    logic unused_blink;
    assign unused_blink = ^{bus.in_blink_en, bus.in_blink_index, BLINK_FRAMES[0]};
    assign blink_mask   = '0;
`endif

    assign display = active_reg & ~blink_mask;

    genvar gi;
    for (gi = 0; gi < ROWS; gi++) begin : g_rows
        assign row_data[gi] = display[gi*COLS +: COLS];
    end

    always_comb begin
        cathode_next = {ROWS{~ROW_ON}};
        anode_next   = {COLS{~COL_ON}};
        if (!slot_blank) begin
            cathode_next[row_idx] = ROW_ON;
            anode_next            = row_data[row_idx] ^ {COLS{~COL_ON}};
        end
    end

    always_ff @(posedge in_clka) begin
        if (in_restart) begin
            active_reg     <= '0;
            shadow_reg     <= '0;
            pending_reg    <= 1'b0;
            cathode_reg    <= {ROWS{~ROW_ON}};
            anode_reg      <= {COLS{~COL_ON}};
            row_index_reg  <= '0;
            frame_done_reg <= 1'b0;
        end else begin
            if (bus.in_load)
                shadow_reg <= bus.in_led_array_flat;
            // A load landing on the swap cycle bypasses the shadow straight into the active frame.
            if (frame_end && bus.in_load)
                active_reg <= bus.in_led_array_flat;
            else if (frame_end && pending_reg)
                active_reg <= shadow_reg;
            if (frame_end)
                pending_reg <= 1'b0;
            else if (bus.in_load)
                pending_reg <= 1'b1;
            cathode_reg    <= cathode_next;
            anode_reg      <= anode_next;
            row_index_reg  <= row_idx;
            frame_done_reg <= frame_end;
        end
    end

    assign bus.out_row_cathode  = cathode_reg;
    assign bus.out_column_anode = anode_reg;
    assign bus.out_row_index    = row_index_reg;
    assign bus.out_frame_done   = frame_done_reg;
    assign bus.out_load_pending = pending_reg;

endmodule

// File: tb/tb_snake_matrix_scan.sv
// Self-checking bench for snake_matrix_scan against a cycle-count based reference model.
module tb_snake_matrix_scan;
    import snake_pkg::*;

    localparam int R   = 8;
    localparam int C   = 8;
    localparam int D   = 4;
    localparam int BF  = 2;
    localparam int N   = R * C;
    localparam int F   = R * D;
    localparam int RIW = clog2w(R);
    localparam int VW  = R + C + RIW + 2;

    logic clk = 1'b0;
    logic restart = 1'b1;
    always #5 clk = ~clk;

    snake_matrix_scan_if #(.ROWS(R), .COLS(C)) bus_if ();

    snake_matrix_scan #(
        .ROWS         (R),
        .COLS         (C),
        .DWELL        (D),
        .BLINK_FRAMES (BF)
    ) dut (
        .in_clka    (clk),
        .in_restart (restart),
        .bus        (bus_if)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: k = clock edges since reset release; position in scan is k-1.
    int           k;
    logic [N-1:0] m_active, m_shadow;
    bit           m_pending;
    int           m_bcnt;
    logic [R-1:0] e_cath;
    logic [C-1:0] e_anode;
    int           e_row;
    bit           e_fd;

    task automatic advance();
        logic [N-1:0] shown;
        int p, row, dw;
        bit fe;
        @(posedge clk);
        if (restart) begin
            k = 0; m_active = '0; m_shadow = '0; m_pending = 0; m_bcnt = 0;
            e_cath = '1; e_anode = '0; e_row = 0; e_fd = 0;
        end else begin
            k++;
            p   = k - 1;
            row = (p / D) % R;
            dw  = p % D;
            fe  = (p % F) == F - 1;
            shown = m_active;
`ifdef SNAKE_BLINK_EN
            if (bus_if.in_blink_en && ((m_bcnt / BF) % 2 == 1) && (int'(bus_if.in_blink_index) < N))
                shown[bus_if.in_blink_index] = 1'b0;
            if (!bus_if.in_blink_en) m_bcnt = 0;
            else if (fe) m_bcnt++;
`endif
            e_cath  = '1;
            e_anode = '0;
            if (dw != 0) begin
                e_cath[row] = 1'b0;
                e_anode     = shown[row*C +: C];
            end
            e_row = row;
            e_fd  = fe;
            if (bus_if.in_load) begin
                m_shadow  = bus_if.in_led_array_flat;
                m_pending = 1;
            end
            if (fe) begin
                if (bus_if.in_load) m_active = bus_if.in_led_array_flat;
                else if (m_pending) m_active = m_shadow;
                m_pending = 0;
            end
        end
        #1;
    endtask

    function automatic logic [VW-1:0] obs();
        return {bus_if.out_row_cathode, bus_if.out_column_anode, bus_if.out_row_index,
                bus_if.out_frame_done, bus_if.out_load_pending};
    endfunction

    function automatic logic [VW-1:0] expv();
        return {e_cath, e_anode, RIW'(e_row), e_fd, m_pending};
    endfunction

    function automatic logic [N-1:0] rand_frame();
        logic [N-1:0] f;
        for (int i = 0; i < N; i++) f[i] = 1'($urandom_range(0, 1));
        return f;
    endfunction

    task automatic test_reset();
        int fd_count = 0;
        restart = 1'b1;
        for (int i = 0; i < 3; i++) begin
            advance();
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL reset_values cycle %0d: got %h expected %h", i, obs(), expv());
            end
        end
        restart = 1'b0;
        for (int i = 0; i < 2 * F; i++) begin
            advance();
            if (bus_if.out_frame_done === 1'b1) fd_count++;
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL idle_scan k=%0d: got %h expected %h", k, obs(), expv());
            end
        end
        checks++;
        if (fd_count !== 2) begin
            errors++;
            $display("FAIL frame_done_count: got %0d expected 2", fd_count);
        end
        $display("reset + idle scan: %0d cycles, %0d frame_done pulses", 2 * F, fd_count);
    endtask

    task automatic test_load_mid_frame();
        bit done = 0;
        bit seen = 0;
        for (int i = 0; i < 3 * F; i++) begin
            bus_if.in_load = !done && (k % F == 10);
            if (bus_if.in_load) begin
                bus_if.in_led_array_flat = N'(64'h81);
                done = 1;
                $display("load mid-frame at k=%0d data %h", k, bus_if.in_led_array_flat);
            end
            advance();
            bus_if.in_load = 1'b0;
            if (bus_if.out_row_cathode[0] === 1'b0 && bus_if.out_column_anode === 8'h81) seen = 1;
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL load_mid_frame k=%0d: got %h expected %h", k, obs(), expv());
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL load_mid_frame_row0: got no 81 on row 0 expected 81");
        end
    endtask

    task automatic test_double_load();
        int stage = 0;
        bit seen01 = 0, seenff = 0;
        for (int i = 0; i < 3 * F; i++) begin
            bus_if.in_load = 1'b0;
            if (stage == 0 && k % F == 3) begin
                bus_if.in_load = 1'b1; bus_if.in_led_array_flat = N'(64'h01); stage = 1;
            end else if (stage == 1 && k % F == 12) begin
                bus_if.in_load = 1'b1; bus_if.in_led_array_flat = N'(64'hFF); stage = 2;
            end
            if (bus_if.in_load) $display("double load at k=%0d data %h", k, bus_if.in_led_array_flat);
            advance();
            bus_if.in_load = 1'b0;
            if (bus_if.out_row_cathode[0] === 1'b0 && bus_if.out_column_anode === 8'h01) seen01 = 1;
            if (bus_if.out_row_cathode[0] === 1'b0 && bus_if.out_column_anode === 8'hFF) seenff = 1;
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL double_load k=%0d: got %h expected %h", k, obs(), expv());
            end
        end
        checks++;
        if (seen01 || !seenff) begin
            errors++;
            $display("FAIL double_load_last_wins: got seen01=%0d seenff=%0d expected 0 1", seen01, seenff);
        end
    endtask

    task automatic test_load_on_swap();
        bit done = 0;
        int at = -1;
        logic [N-1:0] d = rand_frame();
        for (int i = 0; i < 2 * F + 4; i++) begin
            bus_if.in_load = !done && ((k + 1) % F == 0);
            if (bus_if.in_load) begin
                bus_if.in_led_array_flat = d;
                done = 1;
                at = i;
                $display("load on swap edge k=%0d data %h", k + 1, d);
            end
            advance();
            bus_if.in_load = 1'b0;
            if (i == at) begin
                checks++;
                if (bus_if.out_load_pending !== 1'b0) begin
                    errors++;
                    $display("FAIL swap_bypass_pending: got %b expected 0", bus_if.out_load_pending);
                end
            end
            if (at >= 0 && i == at + 2) begin
                checks++;
                if (bus_if.out_column_anode !== d[C-1:0]) begin
                    errors++;
                    $display("FAIL swap_bypass_row0: got %h expected %h", bus_if.out_column_anode, d[C-1:0]);
                end
            end
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL load_on_swap k=%0d: got %h expected %h", k, obs(), expv());
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            bus_if.in_load = ($urandom_range(0, 7) == 0);
            if (bus_if.in_load) bus_if.in_led_array_flat = rand_frame();
            if (i % 50 == 0) begin
                bus_if.in_blink_en    = 1'($urandom_range(0, 1));
                bus_if.in_blink_index = 6'($urandom_range(0, N - 1));
            end
            if (bus_if.in_load) $display("random load at k=%0d data %h", k, bus_if.in_led_array_flat);
            advance();
            bus_if.in_load = 1'b0;
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL random k=%0d: got %h expected %h", k, obs(), expv());
            end
        end
        bus_if.in_blink_en = 1'b0;
    endtask

    task automatic test_restart();
        int stage = 0;
        for (int i = 0; i < 4 * F && stage < 2; i++) begin
            bus_if.in_load = (stage == 0) && (k % F == 2);
            if (bus_if.in_load) begin
                bus_if.in_led_array_flat = rand_frame();
                stage = 1;
                $display("load before restart at k=%0d data %h", k, bus_if.in_led_array_flat);
            end else if (stage == 1 && k % F == 5 * D + 2) begin
                checks++;
                if (bus_if.out_load_pending !== 1'b1) begin
                    errors++;
                    $display("FAIL restart_precondition: got pending %b expected 1", bus_if.out_load_pending);
                end
                restart = 1'b1;
                stage = 2;
                $display("restart at row 5 dwell 2, k=%0d", k);
            end
            advance();
            bus_if.in_load = 1'b0;
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL restart_lead k=%0d: got %h expected %h", k, obs(), expv());
            end
        end
        restart = 1'b0;
        for (int i = 0; i < F + 6; i++) begin
            advance();
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL after_restart k=%0d: got %h expected %h", k, obs(), expv());
            end
        end
    endtask

`ifdef SNAKE_BLINK_EN
    task automatic test_blink();
        bit done = 0;
        int n_ff = 0, n_f7 = 0, n_f7_off = 0;
        bus_if.in_blink_en    = 1'b1;
        bus_if.in_blink_index = 6'd27;
        for (int i = 0; i < 7 * F; i++) begin
            bus_if.in_load = !done && (k % F == 3);
            if (bus_if.in_load) begin
                bus_if.in_led_array_flat = '1;
                done = 1;
                $display("blink: load all-ones at k=%0d", k);
            end
            advance();
            bus_if.in_load = 1'b0;
            if (bus_if.out_row_cathode[3] === 1'b0 && bus_if.out_column_anode === 8'hFF) n_ff++;
            if (bus_if.out_row_cathode[3] === 1'b0 && bus_if.out_column_anode === 8'hF7) n_f7++;
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL blink k=%0d: got %h expected %h", k, obs(), expv());
            end
        end
        checks++;
        if (n_ff == 0 || n_f7 == 0) begin
            errors++;
            $display("FAIL blink_alternation: got ff=%0d f7=%0d expected both nonzero", n_ff, n_f7);
        end
        bus_if.in_blink_en = 1'b0;
        for (int i = 0; i < 2 * F; i++) begin
            advance();
            if (bus_if.out_row_cathode[3] === 1'b0 && bus_if.out_column_anode === 8'hF7) n_f7_off++;
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL blink_off k=%0d: got %h expected %h", k, obs(), expv());
            end
        end
        checks++;
        if (n_f7_off != 0) begin
            errors++;
            $display("FAIL blink_disabled_steady: got %0d masked cycles expected 0", n_f7_off);
        end
    endtask
`endif

    initial begin
        bus_if.in_load           = 1'b0;
        bus_if.in_led_array_flat = '0;
        bus_if.in_blink_en       = 1'b0;
        bus_if.in_blink_index    = '0;
        k = 0; m_active = '0; m_shadow = '0; m_pending = 0; m_bcnt = 0;
        e_cath = '1; e_anode = '0; e_row = 0; e_fd = 0;
        test_reset();
        test_load_mid_frame();
        test_double_load();
        test_load_on_swap();
        test_random();
        test_restart();
`ifdef SNAKE_BLINK_EN
        test_blink();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
